// File: rtl/alu_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_addr_unit
// Brief    : Registered execute-stage ALU, PC+4 incrementer and branch-target
//            adder sharing one output register stage (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module alu_addr_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  shamt,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        out_valid,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        overflow,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target
);

    localparam logic [3:0] c_OP_AND   = 4'd0;
    localparam logic [3:0] c_OP_OR    = 4'd1;
    localparam logic [3:0] c_OP_ADD   = 4'd2;
    localparam logic [3:0] c_OP_XOR   = 4'd3;
    localparam logic [3:0] c_OP_NOR   = 4'd4;
    localparam logic [3:0] c_OP_SLTU  = 4'd5;
    localparam logic [3:0] c_OP_SUB   = 4'd6;
    localparam logic [3:0] c_OP_SLT   = 4'd7;
    localparam logic [3:0] c_OP_SLL   = 4'd8;
    localparam logic [3:0] c_OP_SRL   = 4'd9;
    localparam logic [3:0] c_OP_SRA   = 4'd10;
    localparam logic [3:0] c_OP_LUI   = 4'd11;
    localparam logic [3:0] c_OP_SLLV  = 4'd12;
    localparam logic [3:0] c_OP_SRLV  = 4'd13;
    localparam logic [3:0] c_OP_SRAV  = 4'd14;
    localparam logic [3:0] c_OP_PASSB = 4'd15;

    logic        r_out_valid_q;
    logic [31:0] r_alu_out_q;
    logic        r_zero_q;
    logic        r_overflow_q;
    logic [31:0] r_pc_plus4_q;
    logic [31:0] r_branch_target_q;

    logic        w_out_valid_d;
    logic [31:0] w_alu_out_d;
    logic        w_zero_d;
    logic        w_overflow_d;
    logic [31:0] w_pc_plus4_d;
    logic [31:0] w_branch_target_d;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_ovf;
    logic [31:0] w_pc4;

    assign w_sum  = alu_a + alu_b;
    assign w_diff = alu_a - alu_b;
    assign w_pc4  = pc + 32'd4;

    always_comb begin
        w_result = 32'd0;
        w_ovf    = 1'b0;
        case (alu_op)
            c_OP_AND:   w_result = alu_a & alu_b;
            c_OP_OR:    w_result = alu_a | alu_b;
            c_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
            end
            c_OP_XOR:   w_result = alu_a ^ alu_b;
            c_OP_NOR:   w_result = ~(alu_a | alu_b);
            c_OP_SLTU:  w_result = {31'd0, (alu_a < alu_b)};
            c_OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (alu_a[31] != alu_b[31]) && (w_diff[31] != alu_a[31]);
            end
            c_OP_SLT:   w_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            c_OP_SLL:   w_result = alu_b << shamt;
            c_OP_SRL:   w_result = alu_b >> shamt;
            c_OP_SRA:   w_result = $unsigned($signed(alu_b) >>> shamt);
            c_OP_LUI:   w_result = {alu_b[15:0], 16'h0000};
            c_OP_SLLV:  w_result = alu_b << alu_a[4:0];
            c_OP_SRLV:  w_result = alu_b >> alu_a[4:0];
            c_OP_SRAV:  w_result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            c_OP_PASSB: w_result = alu_b;
            default:    w_result = alu_b;
        endcase
    end

    // Results only update on a valid cycle; otherwise the previous values hold.
    always_comb begin
        w_out_valid_d     = in_valid;
        w_alu_out_d       = r_alu_out_q;
        w_zero_d          = r_zero_q;
        w_overflow_d      = r_overflow_q;
        w_pc_plus4_d      = r_pc_plus4_q;
        w_branch_target_d = r_branch_target_q;
        if (in_valid) begin
            w_alu_out_d       = w_result;
            w_zero_d          = (w_result == 32'd0);
            w_overflow_d      = w_ovf;
            w_pc_plus4_d      = w_pc4;
            w_branch_target_d = w_pc4 + {imm[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid_q     <= 1'b0;
            r_alu_out_q       <= 32'd0;
            r_zero_q          <= 1'b0;
            r_overflow_q      <= 1'b0;
            r_pc_plus4_q      <= 32'd0;
            r_branch_target_q <= 32'd0;
        end else begin
            r_out_valid_q     <= w_out_valid_d;
            r_alu_out_q       <= w_alu_out_d;
            r_zero_q          <= w_zero_d;
            r_overflow_q      <= w_overflow_d;
            r_pc_plus4_q      <= w_pc_plus4_d;
            r_branch_target_q <= w_branch_target_d;
        end
    end

    assign out_valid     = r_out_valid_q;
    assign alu_out       = r_alu_out_q;
    assign zero          = r_zero_q;
    assign overflow      = r_overflow_q;
    assign pc_plus4      = r_pc_plus4_q;
    assign branch_target = r_branch_target_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_addr_unit
// Brief    : Directed self-checking bench for alu_addr_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_addr_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        out_valid;
    logic [31:0] alu_out;
    logic        zero;
    logic        overflow;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    int errors = 0;
    int checks = 0;

    alu_addr_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .shamt         (shamt),
        .pc            (pc),
        .imm           (imm),
        .out_valid     (out_valid),
        .alu_out       (alu_out),
        .zero          (zero),
        .overflow      (overflow),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present inputs, then sample outputs 1 ns after the capturing edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [4:0] sh,
                        input logic [31:0] p, input logic [31:0] im);
        in_valid = v; alu_a = a; alu_b = b; alu_op = op; shamt = sh; pc = p; imm = im;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] r, input logic z, input logic ov);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".alu"},   alu_out, r);
        chk({tag, ".zero"},  {31'd0, zero}, {31'd0, z});
        chk({tag, ".ovf"},   {31'd0, overflow}, {31'd0, ov});
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".alu"},   alu_out, 32'd0);
        chk({tag, ".zero"},  {31'd0, zero}, 32'd0);
        chk({tag, ".ovf"},   {31'd0, overflow}, 32'd0);
        chk({tag, ".pc4"},   pc_plus4, 32'd0);
        chk({tag, ".bt"},    branch_target, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        // Operation presented together with reset must be discarded.
        step(1'b1, 32'd1, 32'd1, 4'd2, 5'd0, 32'h0000_1000, 32'd1);
        step(1'b1, 32'd1, 32'd1, 4'd2, 5'd0, 32'h0000_1000, 32'd1);
        chk_cleared("reset");
        reset = 1'b0;

        step(1'b1, 32'h7FFF_FFFF, 32'd1, 4'd2, 5'd0, 32'h0040_0000, 32'hFFFF_FFFF);
        chk_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        chk("add_ovf.pc4", pc_plus4, 32'h0040_0004);
        chk("add_ovf.bt", branch_target, 32'h0040_0000);

        step(1'b1, 32'd5, 32'd5, 4'd6, 5'd0, 32'hFFFF_FFFC, 32'd0);
        chk_res("sub_zero", 32'd0, 1'b1, 1'b0);
        chk("wrap.pc4", pc_plus4, 32'h0000_0000);
        chk("wrap.bt", branch_target, 32'h0000_0000);

        step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7, 5'd0, 32'h0000_0100, 32'd4);
        chk_res("slt", 32'd1, 1'b0, 1'b0);
        chk("b2b.pc4", pc_plus4, 32'h0000_0104);
        chk("b2b.bt", branch_target, 32'h0000_0114);

        step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd5, 5'd0, 32'd0, 32'd0);
        chk_res("sltu", 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'd0, 32'h8000_0000, 4'd10, 5'd4, 32'd0, 32'd0);
        chk_res("sra", 32'hF800_0000, 1'b0, 1'b0);
        step(1'b1, 32'd0, 32'h8000_0000, 4'd9, 5'd4, 32'd0, 32'd0);
        chk_res("srl", 32'h0800_0000, 1'b0, 1'b0);
        step(1'b1, 32'd35, 32'd1, 4'd12, 5'd0, 32'd0, 32'd0);
        chk_res("sllv", 32'h0000_0008, 1'b0, 1'b0);
        step(1'b1, 32'd0, 32'h0000_1234, 4'd11, 5'd0, 32'd0, 32'd0);
        chk_res("lui", 32'h1234_0000, 1'b0, 1'b0);
        step(1'b1, 32'h8000_0000, 32'd1, 4'd6, 5'd0, 32'd0, 32'd0);
        chk_res("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        step(1'b1, 32'd2, 32'd3, 4'd2, 5'd0, 32'd0, 32'd0);
        chk_res("add", 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'd0, 5'd0, 32'd0, 32'd0);
        chk_res("and", 32'h0000_F000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'd1, 5'd0, 32'd0, 32'd0);
        chk_res("or", 32'h0000_FFF0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'd3, 5'd0, 32'd0, 32'd0);
        chk_res("xor", 32'h0000_0FF0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'd4, 5'd0, 32'd0, 32'd0);
        chk_res("nor", 32'hFFFF_000F, 1'b0, 1'b0);
        step(1'b1, 32'd0, 32'd1, 4'd8, 5'd31, 32'd0, 32'd0);
        chk_res("sll", 32'h8000_0000, 1'b0, 1'b0);
        step(1'b1, 32'd4, 32'hF000_0000, 4'd13, 5'd0, 32'd0, 32'd0);
        chk_res("srlv", 32'h0F00_0000, 1'b0, 1'b0);
        step(1'b1, 32'd4, 32'hF000_0000, 4'd14, 5'd0, 32'd0, 32'd0);
        chk_res("srav", 32'hFF00_0000, 1'b0, 1'b0);
        // Overflow-looking operands on a non-arithmetic op must not flag.
        step(1'b1, 32'h7FFF_FFFF, 32'd1, 4'd1, 5'd0, 32'd0, 32'd0);
        chk_res("or_noovf", 32'h7FFF_FFFF, 1'b0, 1'b0);

        step(1'b1, 32'd0, 32'h0000_1234, 4'd15, 5'd0, 32'h0000_2000, 32'd2);
        chk_res("passb", 32'h0000_1234, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0, 4'd2, 5'd0, 32'h0000_9000, 32'd7);
            chk("hold.valid", {31'd0, out_valid}, 32'd0);
            chk("hold.alu", alu_out, 32'h0000_1234);
            chk("hold.zero", {31'd0, zero}, 32'd0);
            chk("hold.pc4", pc_plus4, 32'h0000_2004);
            chk("hold.bt", branch_target, 32'h0000_200C);
        end

        // Reset mid-stream drops the in-flight result.
        step(1'b1, 32'd0, 32'h0000_0055, 4'd15, 5'd0, 32'd0, 32'd0);
        reset = 1'b1;
        step(1'b1, 32'd9, 32'd9, 4'd2, 5'd0, 32'h0000_3000, 32'd1);
        chk_cleared("reset_mid");
        reset = 1'b0;
        step(1'b1, 32'd9, 32'd9, 4'd2, 5'd0, 32'h0000_3000, 32'd1);
        chk_res("after_reset", 32'd18, 1'b0, 1'b0);
        chk("after_reset.pc4", pc_plus4, 32'h0000_3004);
        chk("after_reset.bt", branch_target, 32'h0000_3008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
